sync_fifo_param: RTL

Parametrised synchronous FIFO that succeeds the single-enable FIFO. It adds separate write and read enables, configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between any same-clock producer and consumer as the team's standard buffering element.

---
 rtl/sync_fifo_param.sv | 70 +++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised same-clock FIFO with level thresholds, error pulses and optional FWFT
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter bit FWFT   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LVL must lie in 1..DEPTH");
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LVL must lie in 0..DEPTH-1");
    end
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              rd_acc, wr_acc;
    assign empty        = count == '0;
    assign full         = count == CW'(DEPTH);
    assign almost_full  = count >= CW'(AF_LVL);
    assign almost_empty = count <= CW'(AE_LVL);
    assign rd_acc       = rd_en & ~empty;
    assign wr_acc       = wr_en & (~full | rd_acc);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(wr_acc);
            rd_ptr    <= rd_ptr + PW'(rd_acc);
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end
    // When full with a simultaneous read and write, wr_ptr == rd_ptr; the read still sees the old word
    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) data_out <= '0;
            else if (rd_acc) data_out <= mem[rd_ptr];
        end
    end
endmodule
